// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: owns the program counter, addresses the
// combinational instruction memory and presents each fetched word in a
// one-entry valid/ready slot towards decode. Handles redirects, halt/start
// and sticky faults on misaligned or out-of-range fetch addresses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// st_idle   | not fetching; pc may be redirected; start moves to st_run
// st_run    | fetching one word per cycle whenever the slot can be loaded
// st_fault  | illegal pc seen; fault held until redirect or reset
module instruction_fetch_controller #(
    parameter int WORDSIZE         = 64,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int MEMORY_SIZE      = 1024,
    parameter logic [WORDSIZE-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        halt,
    input  logic                        redirect_valid,
    input  logic [WORDSIZE-1:0]         redirect_pc,
    output logic [WORDSIZE-1:0]         imem_addr,
    input  logic [INSTRUCTION_SIZE-1:0] imem_instruction,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [INSTRUCTION_SIZE-1:0] out_instruction,
    output logic [WORDSIZE-1:0]         out_pc,
    output logic                        fault,
    output logic [31:0]                 fetch_count
);

    typedef enum logic [1:0] {
        st_idle,
        st_run,
        st_fault
    } state_t;

    // Highest word address that still lies fully inside the memory.
    localparam logic [WORDSIZE-1:0] LAST_PC = WORDSIZE'(MEMORY_SIZE - 4);

    state_t                        state, state_n;
    logic [WORDSIZE-1:0]           pc, pc_n;
    logic                          valid_n;
    logic [INSTRUCTION_SIZE-1:0]   instr_n;
    logic [WORDSIZE-1:0]           opc_n;
    logic                          fault_n;
    logic [31:0]                   count_n;
    logic                          handshake;
    logic                          load_slot;
    logic                          pc_illegal;

    assign imem_addr  = pc;
    assign handshake  = out_valid && out_ready;
    assign load_slot  = !out_valid || out_ready;
    assign pc_illegal = (pc[1:0] != 2'b00) || (pc > LAST_PC);

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= st_idle;
            pc              <= RESET_PC;
            out_valid       <= 1'b0;
            out_instruction <= '0;
            out_pc          <= '0;
            fault           <= 1'b0;
            fetch_count     <= '0;
        end else begin
            state           <= state_n;
            pc              <= pc_n;
            out_valid       <= valid_n;
            out_instruction <= instr_n;
            out_pc          <= opc_n;
            fault           <= fault_n;
            fetch_count     <= count_n;
        end
    end

    // Next-state logic: redirect beats halt, halt beats start/load.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        valid_n = out_valid;
        instr_n = out_instruction;
        opc_n   = out_pc;
        fault_n = fault;
        // Handshakes count in every state, including halt/redirect edges.
        count_n = handshake ? fetch_count + 32'd1 : fetch_count;

        case (state)
            st_idle: begin
                valid_n = 1'b0;
                if (redirect_valid) begin
                    pc_n = redirect_pc;
                end else if (start) begin
                    state_n = st_run;
                end
            end
            st_run: begin
                if (redirect_valid) begin
                    // Flush the slot even if decode has not taken it yet.
                    pc_n    = redirect_pc;
                    valid_n = 1'b0;
                end else if (halt) begin
                    // A pending un-accepted word must be delivered first.
                    if (load_slot) begin
                        valid_n = 1'b0;
                        state_n = st_idle;
                    end
                end else if (load_slot) begin
                    if (pc_illegal) begin
                        valid_n = 1'b0;
                        opc_n   = pc;
                        fault_n = 1'b1;
                        state_n = st_fault;
                    end else begin
                        instr_n = imem_instruction;
                        opc_n   = pc;
                        valid_n = 1'b1;
                        pc_n    = pc + WORDSIZE'(4);
                    end
                end
            end
            st_fault: begin
                valid_n = 1'b0;
                if (redirect_valid) begin
                    pc_n    = redirect_pc;
                    fault_n = 1'b0;
                    state_n = st_run;
                end
            end
            default: begin
                state_n = st_idle;
                valid_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
module tb_instruction_fetch_controller;

    logic        clk;
    logic        reset;
    logic        start;
    logic        halt;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] imem_addr;
    logic [31:0] imem_instruction;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [63:0] out_pc;
    logic        fault;
    logic [31:0] fetch_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [31:0] M0 = 32'h00500093;
    localparam logic [31:0] M4 = 32'h00A00113;
    localparam logic [31:0] M8 = 32'h002081B3;
    localparam logic [31:0] MLAST = 32'hC00003FC;

    logic [31:0] mem [0:255];

    instruction_fetch_controller dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .halt             (halt),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_addr        (imem_addr),
        .imem_instruction (imem_instruction),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instruction  (out_instruction),
        .out_pc           (out_pc),
        .fault            (fault),
        .fetch_count      (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory model.
    always_comb begin
        imem_instruction = 32'h0;
        if (imem_addr < 64'd1024) imem_instruction = mem[imem_addr[9:2]];
    end

    typedef struct {
        logic        st;
        logic        hl;
        logic        rv;
        logic [63:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] ei;
        logic [63:0] ep;
        logic        ef;
        logic [31:0] ec;
        logic [63:0] ea;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic hl, input logic rv, input logic [63:0] rpc,
                       input logic rdy, input logic ev, input logic [31:0] ei, input logic [63:0] ep,
                       input logic ef, input logic [31:0] ec, input logic [63:0] ea);
        vec_t v;
        v.st = st; v.hl = hl; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.ei = ei; v.ep = ep; v.ef = ef; v.ec = ec; v.ea = ea;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [31:0] ei,
                             input logic [63:0] ep, input logic ef, input logic [31:0] ec,
                             input logic [63:0] ea);
        check({tag, " out_valid"}, 64'(out_valid), 64'(ev));
        check({tag, " out_instruction"}, 64'(out_instruction), 64'(ei));
        check({tag, " out_pc"}, out_pc, ep);
        check({tag, " fault"}, 64'(fault), 64'(ef));
        check({tag, " fetch_count"}, 64'(fetch_count), 64'(ec));
        check({tag, " imem_addr"}, imem_addr, ea);
    endtask

    task automatic drive(input logic st, input logic hl, input logic rv, input logic [63:0] rpc,
                         input logic rdy);
        start = st; halt = hl; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000 | 32'(i << 2);
        mem[0] = M0;
        mem[1] = M4;
        mem[2] = M8;

        //   st hl rv rpc      rdy  ev  instr  out_pc  f  cnt  addr
        // Sequential fetch, then halt on a handshake edge.
        add(1, 0, 0, 0,       1,   0,  0,     0,      0, 0,  0);
        add(0, 0, 0, 0,       1,   1,  M0,    0,      0, 0,  4);
        add(0, 0, 0, 0,       1,   1,  M4,    4,      0, 1,  8);
        add(0, 0, 0, 0,       1,   1,  M8,    8,      0, 2,  12);
        add(0, 1, 0, 0,       1,   0,  M8,    8,      0, 3,  12);
        // Redirect beats start in idle, then backpressure.
        add(1, 0, 1, 0,       1,   0,  M8,    8,      0, 3,  0);
        add(1, 0, 0, 0,       1,   0,  M8,    8,      0, 3,  0);
        add(0, 0, 0, 0,       0,   1,  M0,    0,      0, 3,  4);
        add(0, 0, 0, 0,       0,   1,  M0,    0,      0, 3,  4);
        add(0, 0, 0, 0,       0,   1,  M0,    0,      0, 3,  4);
        add(0, 0, 0, 0,       0,   1,  M0,    0,      0, 3,  4);
        add(0, 0, 0, 0,       1,   1,  M4,    4,      0, 4,  8);
        // Redirect while stalled flushes the slot.
        add(0, 0, 0, 0,       0,   1,  M4,    4,      0, 4,  8);
        add(0, 0, 1, 8,       0,   0,  M4,    4,      0, 4,  8);
        add(0, 0, 0, 0,       1,   1,  M8,    8,      0, 4,  12);
        // Faults: misaligned / past end, recovery by redirect.
        add(0, 0, 1, 1022,    1,   0,  M8,    8,      0, 5,  1022);
        add(0, 0, 0, 0,       1,   0,  M8,    1022,   1, 5,  1022);
        add(1, 1, 0, 0,       1,   0,  M8,    1022,   1, 5,  1022);
        add(0, 0, 1, 1020,    1,   0,  M8,    1022,   0, 5,  1020);
        add(0, 0, 0, 0,       1,   1,  MLAST, 1020,   0, 5,  1024);
        add(0, 0, 0, 0,       1,   0,  MLAST, 1024,   1, 6,  1024);
        add(0, 0, 1, 0,       1,   0,  MLAST, 1024,   0, 6,  0);
        add(0, 0, 0, 0,       0,   1,  M0,    0,      0, 6,  4);
        // Halt waits for the pending handshake.
        add(0, 1, 0, 0,       0,   1,  M0,    0,      0, 6,  4);
        add(0, 1, 0, 0,       0,   1,  M0,    0,      0, 6,  4);
        add(0, 1, 0, 0,       1,   0,  M0,    0,      0, 7,  4);
        add(1, 0, 0, 0,       1,   0,  M0,    0,      0, 7,  4);
        add(0, 0, 0, 0,       1,   1,  M4,    4,      0, 7,  8);
        // Start in run ignored; redirect beats halt.
        add(1, 0, 0, 0,       1,   1,  M8,    8,      0, 8,  12);
        add(0, 1, 1, 4,       0,   0,  M8,    8,      0, 8,  4);
        add(0, 1, 0, 0,       1,   0,  M8,    8,      0, 8,  4);
        add(0, 0, 0, 0,       1,   0,  M8,    8,      0, 8,  4);

        drive(0, 0, 0, 64'd0, 1'b0);
        reset = 1'b0;
        #2 reset = 1'b1;
        #2 check_all("reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].hl, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].ep,
                      vecs[i].ef, vecs[i].ec, vecs[i].ea);
        end

        // Async reset between edges while running.
        drive(1, 0, 0, 64'd0, 1'b1);
        @(posedge clk); #1;
        drive(0, 0, 0, 64'd0, 1'b1);
        @(posedge clk); #1;
        check_all("pre_reset", 1, M4, 4, 0, 8, 8);
        #2 reset = 1'b1;
        #1 check_all("async_reset", 0, 0, 0, 0, 0, 0);
        #3 reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_all($sformatf("post_reset%0d", i), 0, 0, 0, 0, 0, 0);
        end
        // Latency: start at edge N, first valid at edge N+1.
        drive(1, 0, 0, 64'd0, 1'b1);
        @(posedge clk); #1;
        check_all("restart_n", 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 64'd0, 1'b1);
        @(posedge clk); #1;
        check_all("restart_n1", 1, M0, 0, 0, 0, 4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
